// File: rtl/mor1kx_irq_arbiter.sv
// Interrupt collection and single-request arbitration between tick timer, external pins and the exception unit.
// Optional MOR1KX_PIC_EDGE_EN: edge-triggered, write-1-to-clear PICSR instead of level mirroring.
module mor1kx_irq_arbiter #(
  parameter int NUM_IRQ = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        spr_ttmr_i,
  input  logic               sr_tee_i,
  input  logic               sr_iee_i,
  input  logic               spr_access_i,
  input  logic               spr_we_i,
  input  logic [15:0]        spr_addr_i,
  input  logic [31:0]        spr_dat_i,
  output logic               spr_bus_ack,
  output logic [31:0]        spr_dat_o,
  output logic [31:0]        spr_picmr_o,
  output logic [31:0]        spr_picsr_o,
  output logic               irq_req_o,
  output logic               irq_type_o,
  input  logic               irq_ack_i
);

  localparam logic [15:0]        PICMR_ADDR = 16'h4800;
  localparam logic [15:0]        PICSR_ADDR = 16'h4802;
  localparam logic [NUM_IRQ-1:0] NMI_MASK   = {{(NUM_IRQ-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  logic [NUM_IRQ-1:0] sync1_q, sync2_q;
  logic [NUM_IRQ-1:0] picmr_q, picmr_d;
  logic [NUM_IRQ-1:0] picsr_q, picsr_d;
  state_t             state_q, state_d;
  logic               type_q, type_d;
  logic               picmr_we;
  logic               tick_pend, ext_pend;
  logic               unused_ttmr;

  assign unused_ttmr = ^{spr_ttmr_i[31:29], spr_ttmr_i[27:0]};

  assign picmr_we = spr_access_i & spr_we_i & (spr_addr_i == PICMR_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  // Non-maskable lines 1:0 are forced on at write time so the stored mask is always effective.
  always_comb begin
    picmr_d = picmr_q;
    if (picmr_we)
      picmr_d = spr_dat_i[NUM_IRQ-1:0] | NMI_MASK;
  end

`ifdef MOR1KX_PIC_EDGE_EN
  logic [NUM_IRQ-1:0] hist_q;
  logic               picsr_we;

  assign picsr_we = spr_access_i & spr_we_i & (spr_addr_i == PICSR_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hist_q <= '0;
    else
      hist_q <= sync2_q;
  end

  // Clear is applied before the set so a coincident new edge keeps the bit.
  always_comb begin
    picsr_d = picsr_q;
    if (picsr_we)
      picsr_d = picsr_d & ~spr_dat_i[NUM_IRQ-1:0];
    picsr_d = picsr_d | (sync2_q & ~hist_q);
  end
`else
  assign picsr_d = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      picmr_q <= NMI_MASK;
      picsr_q <= '0;
    end else begin
      picmr_q <= picmr_d;
      picsr_q <= picsr_d;
    end
  end

  assign spr_picmr_o = 32'(picmr_q);
  assign spr_picsr_o = 32'(picsr_q);
  assign spr_bus_ack = spr_access_i;

  always_comb begin
    spr_dat_o = '0;
    if (spr_access_i) begin
      if (spr_addr_i == PICMR_ADDR)
        spr_dat_o = spr_picmr_o;
      else if (spr_addr_i == PICSR_ADDR)
        spr_dat_o = spr_picsr_o;
    end
  end

  assign tick_pend = sr_tee_i & spr_ttmr_i[28];
  assign ext_pend  = sr_iee_i & (|(picsr_q & picmr_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      type_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
    end
  end

  // Tick wins arbitration; the chosen source is frozen for the whole REQ phase.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    case (state_q)
      IDLE: begin
        if (tick_pend) begin
          state_d = REQ;
          type_d  = 1'b0;
        end else if (ext_pend) begin
          state_d = REQ;
          type_d  = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack_i)
          state_d = HOLD;
        else if (type_q ? !ext_pend : !tick_pend)
          state_d = IDLE;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign irq_req_o  = (state_q == REQ);
  assign irq_type_o = type_q;

endmodule

// File: tb/tb_mor1kx_irq_arbiter.sv
// Table-driven, scoreboarded bench for mor1kx_irq_arbiter (level mode table; edge-mode sequence when MOR1KX_PIC_EDGE_EN).
module tb_mor1kx_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_i;
  logic [31:0] spr_ttmr_i;
  logic        sr_tee_i, sr_iee_i;
  logic        spr_access_i, spr_we_i;
  logic [15:0] spr_addr_i;
  logic [31:0] spr_dat_i;
  logic        spr_bus_ack;
  logic [31:0] spr_dat_o, spr_picmr_o, spr_picsr_o;
  logic        irq_req_o, irq_type_o, irq_ack_i;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] T = 32'h1000_0000;

  mor1kx_irq_arbiter #(.NUM_IRQ(32)) dut (
    .clk(clk), .rst(rst_n), .irq_i(irq_i), .spr_ttmr_i(spr_ttmr_i),
    .sr_tee_i(sr_tee_i), .sr_iee_i(sr_iee_i), .spr_access_i(spr_access_i),
    .spr_we_i(spr_we_i), .spr_addr_i(spr_addr_i), .spr_dat_i(spr_dat_i),
    .spr_bus_ack(spr_bus_ack), .spr_dat_o(spr_dat_o), .spr_picmr_o(spr_picmr_o),
    .spr_picsr_o(spr_picsr_o), .irq_req_o(irq_req_o), .irq_type_o(irq_type_o),
    .irq_ack_i(irq_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] irq;
    logic [31:0] ttmr;
    logic        tee, iee, acc, we;
    logic [15:0] addr;
    logic [31:0] dat;
    logic        ack;
    logic        req, typ;
    logic [31:0] picsr, picmr, dato;
  } vec_t;

  vec_t vecs[39];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    irq_i = v.irq; spr_ttmr_i = v.ttmr; sr_tee_i = v.tee; sr_iee_i = v.iee;
    spr_access_i = v.acc; spr_we_i = v.we; spr_addr_i = v.addr;
    spr_dat_i = v.dat; irq_ack_i = v.ack;
  endtask

  task automatic idle_inputs();
    irq_i = '0; spr_ttmr_i = '0; sr_tee_i = 0; sr_iee_i = 0;
    spr_access_i = 0; spr_we_i = 0; spr_addr_i = '0; spr_dat_i = '0; irq_ack_i = 0;
  endtask

  task automatic spr_wr(input logic [15:0] a, input logic [31:0] d);
    spr_access_i = 1; spr_we_i = 1; spr_addr_i = a; spr_dat_i = d;
  endtask

  task automatic spr_off();
    spr_access_i = 0; spr_we_i = 0; spr_addr_i = '0; spr_dat_i = '0;
  endtask

  initial begin
    vec_t e;
    //            irq    ttmr tee iee acc we addr     dat    ack  req typ picsr  picmr  dato
    vecs[0]  = '{32'h0,  T,   1,  0,  0,  0, 16'h0,   32'h0, 0,   1,  0,  32'h0, 32'h3, 32'h0};
    vecs[1]  = '{32'h0,  T,   1,  0,  0,  0, 16'h0,   32'h0, 0,   1,  0,  32'h0, 32'h3, 32'h0};
    vecs[2]  = '{32'h0,  T,   1,  0,  0,  0, 16'h0,   32'h0, 1,   0,  0,  32'h0, 32'h3, 32'h0};
    vecs[3]  = '{32'h0,  T,   1,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h3, 32'h0};
    vecs[4]  = '{32'h0,  T,   1,  0,  0,  0, 16'h0,   32'h0, 0,   1,  0,  32'h0, 32'h3, 32'h0};
    vecs[5]  = '{32'h0,  T,   1,  0,  0,  0, 16'h0,   32'h0, 1,   0,  0,  32'h0, 32'h3, 32'h0};
    vecs[6]  = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h3, 32'h0};
    vecs[7]  = '{32'h0,  0,   0,  0,  1,  1, 16'h4800,32'h10,0,   0,  0,  32'h0, 32'h13,32'h13};
    vecs[8]  = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h13,32'h0};
    vecs[9]  = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h13,32'h0};
    vecs[10] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h10,32'h13,32'h0};
    vecs[11] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   1,  1,  32'h10,32'h13,32'h0};
    vecs[12] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 1,   0,  0,  32'h10,32'h13,32'h0};
    vecs[13] = '{32'h0,  0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h10,32'h13,32'h0};
    vecs[14] = '{32'h0,  0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   1,  1,  32'h10,32'h13,32'h0};
    vecs[15] = '{32'h0,  0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   1,  1,  32'h0, 32'h13,32'h0};
    vecs[16] = '{32'h0,  0,   0,  1,  1,  0, 16'h4802,32'h0, 0,   0,  0,  32'h0, 32'h13,32'h0};
    vecs[17] = '{32'h1,  T,   1,  1,  0,  0, 16'h0,   32'h0, 0,   1,  0,  32'h0, 32'h13,32'h0};
    vecs[18] = '{32'h1,  T,   1,  1,  0,  0, 16'h0,   32'h0, 0,   1,  0,  32'h0, 32'h13,32'h0};
    vecs[19] = '{32'h1,  T,   1,  1,  0,  0, 16'h0,   32'h0, 0,   1,  0,  32'h1, 32'h13,32'h0};
    vecs[20] = '{32'h1,  T,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h1, 32'h13,32'h0};
    vecs[21] = '{32'h1,  T,   0,  1,  0,  0, 16'h0,   32'h0, 0,   1,  1,  32'h1, 32'h13,32'h0};
    vecs[22] = '{32'h1,  T,   0,  1,  0,  0, 16'h0,   32'h0, 1,   0,  0,  32'h1, 32'h13,32'h0};
    vecs[23] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h1, 32'h13,32'h0};
    vecs[24] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h1, 32'h13,32'h0};
    vecs[25] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h13,32'h0};
    vecs[26] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 1,   0,  0,  32'h0, 32'h13,32'h0};
    vecs[27] = '{32'h0,  0,   0,  0,  1,  1, 16'h4800,32'h0, 0,   0,  0,  32'h0, 32'h3, 32'h3};
    vecs[28] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h3, 32'h0};
    vecs[29] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h3, 32'h0};
    vecs[30] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h10,32'h3, 32'h0};
    vecs[31] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h10,32'h3, 32'h0};
    vecs[32] = '{32'h10, 0,   0,  1,  1,  1, 16'h4802,32'h10,0,   0,  0,  32'h10,32'h3, 32'h10};
    vecs[33] = '{32'h10, 0,   0,  1,  1,  1, 16'h4800,32'h10,0,   0,  0,  32'h10,32'h13,32'h13};
    vecs[34] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 0,   1,  1,  32'h10,32'h13,32'h0};
    vecs[35] = '{32'h10, 0,   0,  1,  0,  0, 16'h0,   32'h0, 1,   0,  0,  32'h10,32'h13,32'h0};
    vecs[36] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h10,32'h13,32'h0};
    vecs[37] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h10,32'h13,32'h0};
    vecs[38] = '{32'h0,  0,   0,  0,  0,  0, 16'h0,   32'h0, 0,   0,  0,  32'h0, 32'h13,32'h0};

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    step(); step();
    chk("rst_req", {31'b0, irq_req_o}, 32'h0);
    chk("rst_type", {31'b0, irq_type_o}, 32'h0);
    spr_access_i = 1; spr_addr_i = 16'h4800; #1;
    chk("rst_picmr_rd", spr_dat_o, 32'h3);
    chk("rst_bus_ack", {31'b0, spr_bus_ack}, 32'h1);
    spr_addr_i = 16'h4802; #1;
    chk("rst_picsr_rd", spr_dat_o, 32'h0);
    spr_addr_i = 16'h1234; #1;
    chk("other_addr_rd", spr_dat_o, 32'h0);
    spr_off(); #1;
    chk("bus_ack_idle", {31'b0, spr_bus_ack}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_req", {31'b0, irq_req_o}, 32'h0);

`ifndef MOR1KX_PIC_EDGE_EN
    for (int i = 0; i < 39; i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_req", i), {31'b0, irq_req_o}, {31'b0, e.req});
      if (e.req)
        chk($sformatf("v%0d_type", i), {31'b0, irq_type_o}, {31'b0, e.typ});
      chk($sformatf("v%0d_picsr", i), spr_picsr_o, e.picsr);
      chk($sformatf("v%0d_picmr", i), spr_picmr_o, e.picmr);
      chk($sformatf("v%0d_dato", i), spr_dat_o, e.dato);
    end
    idle_inputs();
    step(); step(); step();
`else
    // Pulse irq[5] for three cycles: bit latches and survives the line dropping
    irq_i = 32'h20;
    step(); step(); step();
    irq_i = '0;
    step(); step(); step();
    chk("edge_latched", spr_picsr_o, 32'h20);
    spr_wr(16'h4802, 32'h20);
    step();
    spr_off();
    chk("edge_w1c", spr_picsr_o, 32'h0);
    irq_i = 32'h20;
    step(); step();
    spr_wr(16'h4802, 32'h20);
    step();
    spr_off();
    chk("edge_set_wins", spr_picsr_o, 32'h20);
    step();
    chk("edge_no_reclear", spr_picsr_o, 32'h20);
    spr_wr(16'h4802, 32'h20);
    step();
    spr_off();
    chk("edge_w1c_2", spr_picsr_o, 32'h0);
    irq_i = '0;
    step(); step(); step();
    chk("edge_fall_nop", spr_picsr_o, 32'h0);
`endif

    // Async reset mid-REQ drops the request before the next edge
    sr_tee_i = 1; spr_ttmr_i = T;
    step();
    chk("areq_up", {31'b0, irq_req_o}, 32'h1);
    spr_wr(16'h4800, 32'hF0);
    step();
    spr_off();
    chk("areq_picmr_wr", spr_picmr_o, 32'hF3);
    #2 rst_n = 1'b0;
    #1;
    chk("areq_async_drop", {31'b0, irq_req_o}, 32'h0);
    chk("areq_async_picmr", spr_picmr_o, 32'h3);
    sr_tee_i = 0;
    step();
    rst_n = 1'b1;
    step();
    chk("areq_after_rel", {31'b0, irq_req_o}, 32'h0);
    sr_tee_i = 1;
    step();
    chk("areq_idle_req", {31'b0, irq_req_o}, 32'h1);
    chk("areq_idle_type", {31'b0, irq_type_o}, 32'h0);
    irq_ack_i = 1;
    step();
    irq_ack_i = 0;
    chk("areq_hold", {31'b0, irq_req_o}, 32'h0);
    step();
    chk("areq_hold_idle", {31'b0, irq_req_o}, 32'h0);
    step();
    chk("areq_rereq", {31'b0, irq_req_o}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
